// File: rtl/wb_fifo_pkg.sv
// Shared definitions for the wb_fifo Wishbone mailbox: register map,
// status bit positions, control bit positions and the status word builder.
package wb_fifo_pkg;

   localparam logic [3:0] WB_FIFO_ADR_DATA   = 4'd0;
   localparam logic [3:0] WB_FIFO_ADR_STATUS = 4'd1;

   localparam int WB_FIFO_ST_EMPTY   = 16;
   localparam int WB_FIFO_ST_FULL    = 17;
   localparam int WB_FIFO_CTRL_FLUSH = 0;

   // Pack the STATUS register: [15:0] count, [16] empty, [17] full, rest zero.
   function automatic logic [31:0] wb_fifo_status(input logic [15:0] count,
                                                  input logic        empty,
                                                  input logic        full);
      logic [31:0] word;
      word                   = 32'd0;
      word[15:0]             = count;
      word[WB_FIFO_ST_EMPTY] = empty;
      word[WB_FIFO_ST_FULL]  = full;
      return word;
   endfunction

endpackage

// File: rtl/wb_fifo_sync.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count.
// Flush beats push beats pop; the bus side never asks for push and pop together.
module fifo_sync #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;

   // Storage write on push; contents are deliberately not cleared by reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !rst_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Next pointer and count values for flush, push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (push_i) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         count_d  = count_q + (AW+1)'(1);
      end else if (pop_i) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_q - (AW+1)'(1);
      end else begin
         count_d  = count_q;
      end
   end

   // Pointer and count registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/wb_fifo.sv
// Wishbone B4 pipelined responder fronting a 32-bit FIFO mailbox.
// Decodes DATA/STATUS, generates stall, and registers ack, read data and irq.
module wb_fifo
   import wb_fifo_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_stall_o,
   output logic        wb_ack_o,
   output logic        int_fifo_rx
);

   localparam int AW = $clog2(DEPTH);

   logic          req_s, adr_data_s, adr_status_s;
   logic          stall_s, accept_s;
   logic          push_s, pop_s, flush_s;
   logic [31:0]   rdata_s;
   logic          full_s, empty_s;
   logic [AW:0]   count_s;
   logic [16:0]   count_w_s;

   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic          irq_q, irq_d;

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (flush_s),
      .wdata_i (wb_dat_i),
      .rdata_o (rdata_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count_s)
   );

   // Bus decode: stall only DATA accesses that cannot complete right now.
   always_comb begin
      req_s        = wb_cyc_i & wb_stb_i;
      adr_data_s   = (wb_adr_i == WB_FIFO_ADR_DATA);
      adr_status_s = (wb_adr_i == WB_FIFO_ADR_STATUS);
      stall_s      = req_s & adr_data_s &
                     ((wb_we_i & full_s) | (!wb_we_i & empty_s));
      accept_s     = req_s & !stall_s;
      push_s       = accept_s & wb_we_i & adr_data_s;
      pop_s        = accept_s & !wb_we_i & adr_data_s;
      flush_s      = accept_s & wb_we_i & adr_status_s &
                     wb_dat_i[WB_FIFO_CTRL_FLUSH];
      count_w_s    = 17'(count_s);
   end

   // Next ack, read data (held unless a read is accepted) and irq level.
   always_comb begin
      ack_d = accept_s;
      dat_d = dat_q;
      irq_d = irq_q;
      if (accept_s && !wb_we_i) begin
         case (wb_adr_i)
            WB_FIFO_ADR_DATA:   dat_d = rdata_s;
            WB_FIFO_ADR_STATUS: dat_d = wb_fifo_status(count_w_s[15:0], empty_s, full_s);
            default:            dat_d = 32'd0;
         endcase
      end else begin
         dat_d = dat_q;
      end
      // Track the count the FIFO will hold after this edge.
      if (flush_s) begin
         irq_d = 1'b0;
      end else if (push_s) begin
         irq_d = 1'b1;
      end else if (pop_s) begin
         irq_d = (count_w_s != 17'd1);
      end else begin
         irq_d = (count_w_s != 17'd0);
      end
   end

   // Output registers; reset cancels any pending ack.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= 32'd0;
         irq_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         irq_q <= irq_d;
      end
   end

   assign wb_stall_o  = stall_s;
   assign wb_ack_o    = ack_q;
   assign wb_dat_o    = dat_q;
   assign int_fifo_rx = irq_q;

endmodule

// File: doc/wb_fifo.md
# wb_fifo

Wishbone B4 pipelined responder that buffers 32-bit words in a synchronous FIFO. It is the target end of the initiator pattern used by our top-level state machines: write requests push words, read requests pop them, and `wb_stall_o` holds off requests that cannot complete. `int_fifo_rx` tells the initiator when a read will succeed. It sits beside `wb_uart` on the same bus as a software-visible mailbox and loopback buffer.

## Interface

Parameters:
- `DEPTH`, default 16: number of 32-bit entries; power of two, 2..65536.

Ports:
- `wb_clk_i` in 1: single clock; all logic is on its rising edge.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: request strobe.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_adr_i` in 4: register address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data; valid while `wb_ack_o` = 1.
- `wb_stall_o` out 1: request not accepted this cycle.
- `wb_ack_o` out 1: completion strobe, one cycle per accepted request.
- `int_fifo_rx` out 1: FIFO not empty.

## Operation

- Register map:
  - adr 0 DATA: write pushes `wb_dat_i`; read pops the oldest word into `wb_dat_o`.
  - adr 1 STATUS: read returns [15:0] count, [16] empty, [17] full, and 0 elsewhere. A write with `wb_dat_i[0]` = 1 flushes the FIFO. A write with bit 0 = 0 has no effect.
  - All other addresses: never stall; writes are ignored; reads return 0.
- A request is `req = wb_cyc_i & wb_stb_i`. It is accepted when `req & !wb_stall_o`.
- `wb_stall_o = req & adr==0 & ((wb_we_i & full) | (!wb_we_i & empty))`. This is combinational from the inputs and the registered count.
- Side effects commit at the acceptance edge:
  - push: write pointer +1, count +1.
  - pop: read pointer +1, count −1.
  - flush: both pointers and count go to 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- Count is log2(DEPTH)+1 bits. Full means count == DEPTH; empty means count == 0.
- `int_fifo_rx` = (count != 0), registered with count.
- Only one request can be accepted per cycle, so push and pop never happen in the same cycle.
- A stalled request has no side effect and produces no ack.
- `wb_cyc_i` falling after acceptance does not undo the side effect. The ack is still emitted on the next cycle.
- Reset mid-operation: a pending ack is cancelled and all state clears. Stored data is not cleared and is unreachable after reset.

## Timing

- Reset values: `wb_ack_o` = 0, `wb_dat_o` = 0, `int_fifo_rx` = 0, count = 0, pointers = 0. `wb_stall_o` follows its equation.
- Latency: request accepted at edge N gives `wb_ack_o` = 1 and valid `wb_dat_o` during cycle N+1 (exactly 1 cycle).
- `wb_dat_o` is registered. It updates only on accepted reads and holds its value otherwise.
- Pipelined back-to-back requests are accepted every cycle, giving one ack per cycle.
- Stall in a cycle reflects count after all preceding accepted requests. A pop at edge N makes the FIFO non-full for cycle N+1.
- STATUS read data reflects count as of the acceptance edge, before that edge's update. No other request can update count at that same edge.
- `int_fifo_rx` rises in the cycle after the push edge. It falls in the cycle after the popping or flushing edge.

## Structure

- Shared package holds:
  - register addresses `WB_FIFO_ADR_DATA` = 0 and `WB_FIFO_ADR_STATUS` = 1;
  - status bit positions `WB_FIFO_ST_EMPTY` = 16 and `WB_FIFO_ST_FULL` = 17;
  - flush bit `WB_FIFO_CTRL_FLUSH` = 0.
- Sub-module `fifo_sync` (parameter `DEPTH`, width 32) holds storage, pointers and count, with push, pop, flush, rdata, full, empty and count ports.
- `wb_fifo` holds the bus decode, stall, ack and data-out registers.

## Test plan

- Reset, then idle: `wb_ack_o` = 0, `int_fifo_rx` = 0, `wb_dat_o` = 0. STATUS read returns 0x00010000.
- Write 0xDEADBEEF then 0x12345678 to adr 0, then read adr 0 twice: each ack arrives 1 cycle after acceptance; reads return 0xDEADBEEF then 0x12345678; `int_fifo_rx` is 1 between the first push and the last pop.
- Push 16 words (DEPTH = 16), then attempt a 17th: `wb_stall_o` = 1 and no ack until a pop is accepted. STATUS reads 0x00020010.
- Read adr 0 when empty: `wb_stall_o` = 1, no ack, count unchanged. Then push one word: the held read is accepted the cycle after the push and returns that word.
- Push 20 and pop 20 in an interleaved pattern, wrapping the pointers: data order is preserved. Write 1 to STATUS with 5 entries present: count becomes 0 and `int_fifo_rx` goes to 0 the next cycle.
- Assert `wb_rst_i` the cycle after a read is accepted: no ack in the next cycle, and count = 0.
